// File: rtl/retire_trace_buf.sv
// Purpose : multi-lane commit-trace recorder. It tags retire events with sequential INUMs,
//           buffers them in a circular FIFO and drains one entry per cycle to a trace sink.
// Latency : a pushed entry reaches the head on the cycle after capture. There is no bypass path.
// Backpr. : out_valid/out_ready. The head holds while stalled. When the FIFO is full, excess
//           retires are dropped and counted. A pop in the same cycle does not free a slot for
//           that cycle's pushes.
// Build   : define TRACE_NOP_FILTER_EN to number NOP retires without storing them.
// Ports   : clk, rst (synchronous, active-low)
//           ret_*       : per-lane retire bundle from writeback (lane i at slice i)
//           out_*       : head entry plus the out_valid/out_ready handshake
//           cycle_count, inst_count, halted, overflow, drop_count : status
module retire_trace_buf #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        ret_valid,
  input  logic [LANES*DATA_W-1:0] ret_pc,
  input  logic [LANES-1:0]        ret_regwrite,
  input  logic [LANES*3-1:0]      ret_wreg,
  input  logic [LANES*DATA_W-1:0] ret_wdata,
  input  logic [LANES-1:0]        ret_memread,
  input  logic [LANES-1:0]        ret_memwrite,
  input  logic [LANES*DATA_W-1:0] ret_maddr,
  input  logic [LANES*DATA_W-1:0] ret_mdata,
  input  logic [LANES-1:0]        ret_halt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inum,
  output logic [DATA_W-1:0]       out_pc,
  output logic [4:0]              out_kind,
  output logic [2:0]              out_wreg,
  output logic [DATA_W-1:0]       out_wdata,
  output logic [DATA_W-1:0]       out_maddr,
  output logic [DATA_W-1:0]       out_mdata,
  output logic [31:0]             cycle_count,
  output logic [31:0]             inst_count,
  output logic                    halted,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(LANES + 1);

  typedef struct packed {
    logic [31:0]       inum;
    logic [DATA_W-1:0] pc;
    logic [4:0]        kind;   // {halt, memwrite, memread, regwrite, nop}
    logic [2:0]        wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d, free;
  logic [31:0]      cycle_count_q, cycle_count_d, inst_count_q, inst_count_d;
  logic             halted_q, halted_d, overflow_q, overflow_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic [16:0]      drop_sum;
  logic [CNT_W-1:0] n_acc, n_push, n_drop;
  logic             pop, halt_seen, do_push;
  entry_t           lane_e, head;

  always_comb begin
    mem_d         = mem_q;
    lane_e        = '0;
    n_acc         = '0;
    n_push        = '0;
    n_drop        = '0;
    halt_seen     = 1'b0;
    do_push       = 1'b0;
    // Free space is taken before this cycle's pop, so a full FIFO drops even while draining.
    free          = OCC_W'(DEPTH) - occ_q;
    pop           = (occ_q != '0) && out_ready;
    cycle_count_d = cycle_count_q + 32'd1;

    for (int i = 0; i < LANES; i++) begin
      lane_e = '0;
      // Lanes above an accepted halt in the same cycle are ignored entirely.
      if (!halted_q && !halt_seen && ret_valid[i]) begin
        lane_e.inum  = inst_count_q + 32'(n_acc);
        lane_e.pc    = ret_pc[i*DATA_W +: DATA_W];
        lane_e.kind  = {ret_halt[i], ret_memwrite[i], ret_memread[i], ret_regwrite[i],
                        !(ret_halt[i] | ret_memwrite[i] | ret_memread[i] | ret_regwrite[i])};
        lane_e.wreg  = ret_wreg[i*3 +: 3];
        lane_e.wdata = ret_wdata[i*DATA_W +: DATA_W];
        lane_e.maddr = ret_maddr[i*DATA_W +: DATA_W];
        lane_e.mdata = ret_mdata[i*DATA_W +: DATA_W];
        n_acc        = n_acc + CNT_W'(1);
`ifdef TRACE_NOP_FILTER_EN
        do_push = !lane_e.kind[0];
`else
        do_push = 1'b1;
`endif
        if (do_push) begin
          if (OCC_W'(n_push) < free) begin
            mem_d[wr_ptr_q + PTR_W'(n_push)] = lane_e;
            n_push = n_push + CNT_W'(1);
          end else begin
            // A dropped event still consumes its INUM.
            n_drop = n_drop + CNT_W'(1);
          end
        end
        if (ret_halt[i]) begin
          halt_seen = 1'b1;
        end
      end
    end

    wr_ptr_d     = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    occ_d        = occ_q + OCC_W'(n_push) - OCC_W'(pop);
    inst_count_d = inst_count_q + 32'(n_acc);
    halted_d     = halted_q | halt_seen;
    overflow_d   = overflow_q | (n_drop != '0);
    drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      cycle_count_q <= '0;
      inst_count_q  <= '0;
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
      halted_q      <= halted_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // The storage array needs no reset: occupancy gates everything that leaves the block.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (occ_q != '0);
  assign out_inum    = out_valid ? head.inum  : '0;
  assign out_pc      = out_valid ? head.pc    : '0;
  assign out_kind    = out_valid ? head.kind  : '0;
  assign out_wreg    = out_valid ? head.wreg  : '0;
  assign out_wdata   = out_valid ? head.wdata : '0;
  assign out_maddr   = out_valid ? head.maddr : '0;
  assign out_mdata   = out_valid ? head.mdata : '0;
  assign cycle_count = cycle_count_q;
  assign inst_count  = inst_count_q;
  assign halted      = halted_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Purpose : scoreboard bench for retire_trace_buf with a queue-based reference model.
// Latency : the model predicts each captured entry when stimulus is issued.
// Backpr. : a negedge monitor pops the prediction on every head handshake and compares it.
module tb_retire_trace_buf;
  localparam int LANES  = 2;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [LANES-1:0]        ret_valid, ret_regwrite, ret_memread, ret_memwrite, ret_halt;
  logic [LANES*DATA_W-1:0] ret_pc, ret_wdata, ret_maddr, ret_mdata;
  logic [LANES*3-1:0]      ret_wreg;
  logic                    out_valid, out_ready;
  logic [31:0]             out_inum, cycle_count, inst_count;
  logic [DATA_W-1:0]       out_pc, out_wdata, out_maddr, out_mdata;
  logic [4:0]              out_kind;
  logic [2:0]              out_wreg;
  logic                    halted, overflow;
  logic [15:0]             drop_count;

  retire_trace_buf #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite), .ret_wreg(ret_wreg),
    .ret_wdata(ret_wdata), .ret_memread(ret_memread), .ret_memwrite(ret_memwrite),
    .ret_maddr(ret_maddr), .ret_mdata(ret_mdata), .ret_halt(ret_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_inum(out_inum), .out_pc(out_pc),
    .out_kind(out_kind), .out_wreg(out_wreg), .out_wdata(out_wdata), .out_maddr(out_maddr),
    .out_mdata(out_mdata), .cycle_count(cycle_count), .inst_count(inst_count),
    .halted(halted), .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    logic [31:0] inum;
    logic [15:0] pc;
    logic [4:0]  kind;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state. m_occ mirrors what the DUT holds right now.
  int          m_occ = 0, m_occ_nxt = 0, m_drop = 0;
  logic [31:0] m_inst = 0, m_cycle = 0;
  bit          m_halted = 0, m_ovf = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_lanes();
    ret_valid = '0; ret_regwrite = '0; ret_memread = '0; ret_memwrite = '0; ret_halt = '0;
    ret_pc = '0; ret_wdata = '0; ret_maddr = '0; ret_mdata = '0; ret_wreg = '0;
  endtask

  task automatic set_lane(input int i, input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                          input logic [15:0] wdata, input logic mr, input logic mw,
                          input logic [15:0] maddr, input logic [15:0] mdata, input logic hl);
    ret_valid[i] = 1'b1; ret_regwrite[i] = rw; ret_memread[i] = mr; ret_memwrite[i] = mw;
    ret_halt[i] = hl; ret_pc[i*DATA_W +: DATA_W] = pc; ret_wreg[i*3 +: 3] = wreg;
    ret_wdata[i*DATA_W +: DATA_W] = wdata; ret_maddr[i*DATA_W +: DATA_W] = maddr;
    ret_mdata[i*DATA_W +: DATA_W] = mdata;
  endtask

  // Applies the rules for one clock edge to the current inputs.
  task automatic model_step();
    int pushed = 0;
    int free;
    bit pop, keep, stop = 0;
    exp_t e;
    if (!rst) begin
      m_occ_nxt = 0; m_inst = 0; m_cycle = 0; m_halted = 0; m_ovf = 0; m_drop = 0;
      exp_q.delete();
    end else begin
      m_cycle = m_cycle + 1;
      pop  = (m_occ != 0) && out_ready;
      free = DEPTH - m_occ;
      for (int i = 0; i < LANES; i++) begin
        if (!m_halted && !stop && ret_valid[i]) begin
          e.inum  = m_inst;
          m_inst  = m_inst + 1;
          e.pc    = ret_pc[i*DATA_W +: DATA_W];
          e.kind  = {ret_halt[i], ret_memwrite[i], ret_memread[i], ret_regwrite[i],
                     !(ret_halt[i] | ret_memwrite[i] | ret_memread[i] | ret_regwrite[i])};
          e.wreg  = ret_wreg[i*3 +: 3];
          e.wdata = ret_wdata[i*DATA_W +: DATA_W];
          e.maddr = ret_maddr[i*DATA_W +: DATA_W];
          e.mdata = ret_mdata[i*DATA_W +: DATA_W];
          keep = 1;
`ifdef TRACE_NOP_FILTER_EN
          keep = !e.kind[0];
`endif
          if (keep) begin
            if (pushed < free) begin
              exp_q.push_back(e);
              pushed++;
            end else begin
              m_ovf  = 1;
              m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            end
          end
          if (ret_halt[i]) stop = 1;
        end
      end
      if (stop) m_halted = 1;
      m_occ_nxt = m_occ + pushed - (pop ? 1 : 0);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    m_occ = m_occ_nxt;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_lanes();
    step();
    rst = 1'b1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_cycle"}, cycle_count, m_cycle);
    chk({tag, "_inst"}, inst_count, m_inst);
    chk({tag, "_halted"}, halted, m_halted);
    chk({tag, "_overflow"}, overflow, m_ovf);
    chk({tag, "_drop"}, drop_count, m_drop[15:0]);
    chk({tag, "_valid"}, out_valid, m_occ != 0);
  endtask

  // Monitor: compares each handshake with the oldest prediction and checks that a stalled head holds.
  initial begin
    bit          prev_stall = 0;
    logic [31:0] p_inum = 0;
    logic [15:0] p_pc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_entry", {out_inum, out_pc}, {p_inum, p_pc});
        end
        chk("mon_valid", out_valid, m_occ != 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_underflow: got entry inum %0h, none expected", out_inum);
          end else begin
            e = exp_q.pop_front();
            chk("sb_entry", {out_inum, out_pc, out_kind, out_wreg, out_wdata, out_maddr, out_mdata},
                {e.inum, e.pc, e.kind, e.wreg, e.wdata, e.maddr, e.mdata});
          end
        end
        prev_stall = out_valid && !out_ready;
        p_inum = out_inum;
        p_pc = out_pc;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    int cnt;
    logic [31:0] r;
    clear_lanes();
    out_ready = 1'b0;
    rst = 1'b0;
    step();
    step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_inst", inst_count, 32'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_data", {out_inum, out_pc, out_kind, out_wreg, out_wdata, out_maddr, out_mdata}, 128'd0);
    rst = 1'b1;

    // Two-lane capture: a regwrite, then a store.
    out_ready = 1'b1;
    set_lane(0, 16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0, 16'h0, 0);
    set_lane(1, 16'h0002, 0, 3'd0, 16'h0000, 0, 1, 16'h0040, 16'h1234, 0);
    step();
    clear_lanes();
    chk("a_head0_inum", out_inum, 32'd0);
    step();
    chk("a_head1_inum", out_inum, 32'd1);
    chk("a_head1_kind", out_kind, 5'b01000);
    chk("a_head1_maddr", out_maddr, 16'h0040);
    chk("a_head1_mdata", out_mdata, 16'h1234);
    step(); step();

    // Fill past capacity while stalled.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      set_lane(0, 16'(4 * c), 1, 3'd2, 16'(c), 0, 0, 16'h0, 16'h0, 0);
      set_lane(1, 16'(4 * c + 2), 1, 3'd3, 16'(c + 100), 0, 0, 16'h0, 16'h0, 0);
      step();
    end
    clear_lanes();
    chk("b_overflow", overflow, 1'b1);
    chk("b_drop", drop_count, 16'd2);
    chk("b_inst", inst_count, 32'd18);
    chk_counters("b");

    // Full FIFO with a pop in the same cycle: the new retire is still dropped.
    out_ready = 1'b1;
    set_lane(0, 16'h0100, 1, 3'd4, 16'hBEEF, 0, 0, 16'h0, 16'h0, 0);
    step();
    clear_lanes();
    chk("c_drop", drop_count, 16'd3);
    cnt = 0;
    while (out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    chk("c_occupancy", cnt, 15);

    // Reset with five entries still queued.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 16'(c), 0, 3'd0, 16'h0, 1, 0, 16'(c + 8), 16'h0, 0);
      if (c < 2) set_lane(1, 16'(c + 1), 1, 3'd5, 16'h7, 0, 0, 16'h0, 16'h0, 0);
      step();
      clear_lanes();
    end
    chk("d_queued", out_valid, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("d_valid", out_valid, 1'b0);
    chk("d_inst", inst_count, 32'd0);
    chk("d_cycle", cycle_count, 32'd0);

    // A halt in lane 0 masks lane 1 and every later retire.
    out_ready = 1'b1;
    set_lane(0, 16'h0010, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    set_lane(1, 16'h0012, 1, 3'd6, 16'h0099, 0, 0, 16'h0, 16'h0, 0);
    step();
    chk("e_halted", halted, 1'b1);
    chk("e_inst", inst_count, 32'd1);
    chk("e_kind", out_kind, 5'b10000);
    for (int c = 0; c < 3; c++) step();
    clear_lanes();
    chk("e_inst_after", inst_count, 32'd1);
    chk_counters("e");

`ifdef TRACE_NOP_FILTER_EN
    do_reset();
    out_ready = 1'b1;
    set_lane(0, 16'h0020, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    set_lane(1, 16'h0022, 1, 3'd7, 16'h0042, 0, 0, 16'h0, 16'h0, 0);
    step();
    clear_lanes();
    chk("f_inst", inst_count, 32'd2);
    chk("f_head_inum", out_inum, 32'd1);
    step();
    chk("f_single", out_valid, 1'b0);
`endif

    // Randomised segments with a different sink readiness bias in each.
    for (int seg = 0; seg < 16; seg++) begin
      int bias;
      do_reset();
      bias = $urandom_range(1, 4);
      for (int c = 0; c < 200; c++) begin
        clear_lanes();
        for (int i = 0; i < LANES; i++) begin
          r = $urandom;
          if ($urandom_range(0, 3) != 0)
            set_lane(i, r[31:16], r[0], r[6:4], 16'($urandom), r[1] & ~r[2], r[2] & ~r[1],
                     16'($urandom), 16'($urandom), $urandom_range(0, 99) == 0);
        end
        out_ready = ($urandom_range(0, 4) < bias);
        step();
        if (c % 16 == 15) chk_counters("rnd");
      end
    end

    clear_lanes();
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) step();
    chk("drain_left", exp_q.size(), 0);
    chk_counters("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
